// File: rtl/mdu_if.sv
// mdu_if: E-stage multiply/divide handshake bundle.
// master = pipeline side, slave = mdu_ctrl.
interface mdu_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        D_mdu_use;
  logic        stall;
  logic        busy;
  logic [31:0] E_MDU_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, mdu_op, E_V1, E_V2, D_mdu_use,
    input  stall, busy, E_MDU_out, hi_out, lo_out
  );

  modport slave (
    input  start, mdu_op, E_V1, E_V2, D_mdu_use,
    output stall, busy, E_MDU_out, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage mult/div sequencer owning HI/LO.
// Ports: clk, reset (sync, active-low), mdu (mdu_if.slave):
//   start/mdu_op/E_V1/E_V2/D_mdu_use in;
//   stall/busy/E_MDU_out/hi_out/lo_out out.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave mdu
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic op_mult;
  logic op_multu;
  logic op_div;
  logic op_divu;
  logic op_mfhi;
  logic op_mflo;
  logic op_mthi;
  logic op_mtlo;
  logic is_md;
  logic idle;
  logic accept;

  assign op_mult  = mdu.mdu_op == 4'd1;
  assign op_multu = mdu.mdu_op == 4'd2;
  assign op_div   = mdu.mdu_op == 4'd3;
  assign op_divu  = mdu.mdu_op == 4'd4;
  assign op_mfhi  = mdu.mdu_op == 4'd5;
  assign op_mflo  = mdu.mdu_op == 4'd6;
  assign op_mthi  = mdu.mdu_op == 4'd7;
  assign op_mtlo  = mdu.mdu_op == 4'd8;

  assign is_md  = op_mult | op_multu
                | op_div | op_divu;
  assign idle   = state == IDLE;
  assign accept = idle & mdu.start & is_md;

  // One 64-bit multiplier: signed vs unsigned
  // only changes the operand extension.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        sx;

  assign sx    = op_mult;
  assign mul_a = {{32{sx & mdu.E_V1[31]}},
                  mdu.E_V1};
  assign mul_b = {{32{sx & mdu.E_V2[31]}},
                  mdu.E_V2};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes through
  // the unsigned divider, then fixes signs:
  // quotient negative when signs differ,
  // remainder follows the dividend.
  logic        dsg;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign dsg    = op_div;
  assign a_neg  = dsg & mdu.E_V1[31];
  assign b_neg  = dsg & mdu.E_V2[31];
  assign b_zero = mdu.E_V2 == 32'd0;
  assign ua     = a_neg ? -mdu.E_V1 : mdu.E_V1;
  assign ub     = b_zero ? 32'd1
                : (b_neg ? -mdu.E_V2
                         : mdu.E_V2);
  assign uq     = ua / ub;
  assign ur     = ua % ub;
  assign quo    = (a_neg ^ b_neg) ? -uq : uq;
  assign rem    = a_neg ? -ur : ur;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    unique case (1'b1)
      op_mult, op_multu: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      op_div, op_divu: begin
        // x/0 keeps the current HI/LO
        if (!b_zero) begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: begin
        res_hi = hi;
        res_lo = lo;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == 4'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    mdu.busy  = state == RUN;
    mdu.stall = mdu.D_mdu_use
              & ((state == RUN)
                 | (mdu.start & is_md));
    mdu.E_MDU_out = 32'd0;
    unique case (1'b1)
      op_mfhi: mdu.E_MDU_out = hi;
      op_mflo: mdu.E_MDU_out = lo;
      default: mdu.E_MDU_out = 32'd0;
    endcase
  end

  assign mdu.hi_out = hi;
  assign mdu.lo_out = lo;

  // counter, pending result and HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (state == RUN) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (mdu.start) begin
      if (is_md) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        cnt <= (op_mult | op_multu)
             ? 4'(MULT_CYCLES)
             : 4'(DIV_CYCLES);
      end
      if (op_mthi) hi <= mdu.E_V1;
      if (op_mtlo) lo <= mdu.E_V1;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed + random checks of mdu_ctrl
// against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [31:0] ehi;
  logic [31:0] elo;

  mdu_if bus ();

  mdu_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h want %h",
             tag, obs, exp);
    end
  endtask

  // reference: what HI/LO become after op
  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin
        p = 64'(sa * sb);
        ehi = p[63:32];
        elo = p[31:0];
      end
      4'd2: begin
        p = {32'd0, a} * {32'd0, b};
        ehi = p[63:32];
        elo = p[31:0];
      end
      4'd3: if (b != 0) begin
        q = sa / sb;
        r = sa - q * sb;
        elo = q[31:0];
        ehi = r[31:0];
      end
      4'd4: if (b != 0) begin
        elo = a / b;
        ehi = a % b;
      end
      4'd7: ehi = a;
      4'd8: elo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic dmu);
    int n;
    int cyc;
    logic md;
    md = op >= 1 && op <= 4;
    n  = (op <= 2) ? MC : DC;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdu_op = op;
    bus.E_V1 = a;
    bus.E_V2 = b;
    bus.D_mdu_use = dmu;
    #1;
    chk("stall_acc", {31'd0, bus.stall},
        {31'd0, dmu & md});
    model(op, a, b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mdu_op = 4'd0;
    if (md) begin
      cyc = 0;
      while (bus.busy && cyc < 40) begin
        if (bus.stall !== dmu)
          chk("stall_run", {31'd0, bus.stall},
              {31'd0, dmu});
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("busy_len", cyc, n);
    end
    chk("busy_end", {31'd0, bus.busy}, 32'd0);
    chk("stall_end", {31'd0, bus.stall}, 32'd0);
    chk("hi", bus.hi_out, ehi);
    chk("lo", bus.lo_out, elo);
    bus.D_mdu_use = 1'b0;
  endtask

  task automatic read_op(input logic [3:0] op);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdu_op = op;
    bus.D_mdu_use = 1'b1;
    #1;
    chk("mf_out", bus.E_MDU_out,
        (op == 4'd5) ? ehi : elo);
    chk("mf_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mdu_op = 4'd0;
    bus.D_mdu_use = 1'b0;
    chk("mf_busy", {31'd0, bus.busy}, 32'd0);
    chk("mf_hi", bus.hi_out, ehi);
    chk("mf_lo", bus.lo_out, elo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    tests = 0;
    fails = 0;
    ehi = 32'd0;
    elo = 32'd0;
    bus.start = 1'b0;
    bus.mdu_op = 4'd0;
    bus.E_V1 = 32'd0;
    bus.E_V2 = 32'd0;
    bus.D_mdu_use = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_hi", bus.hi_out, 32'd0);
    chk("rst_lo", bus.lo_out, 32'd0);
    chk("rst_out", bus.E_MDU_out, 32'd0);
    reset = 1'b1;

    run_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult_hi", bus.hi_out, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo_out, 32'hFFFFFFF1);
    read_op(4'd6);
    read_op(4'd5);

    run_op(4'd4, 32'd100, 32'd7, 1'b0);
    chk("divu_lo", bus.lo_out, 32'h0000000E);
    chk("divu_hi", bus.hi_out, 32'h00000002);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo", bus.lo_out, 32'hFFFFFFFD);
    chk("div_hi", bus.hi_out, 32'hFFFFFFFF);

    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run_op(4'd1, 32'd7, 32'd9, 1'b0);

    run_op(4'd7, 32'h12345678, 32'd0, 1'b0);
    run_op(4'd8, 32'h9ABCDEF0, 32'd0, 1'b0);
    run_op(4'd3, 32'd55, 32'd0, 1'b1);
    chk("dz_hi", bus.hi_out, 32'h12345678);
    chk("dz_lo", bus.lo_out, 32'h9ABCDEF0);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.mdu_op = 4'd3;
    bus.E_V1 = 32'd1000;
    bus.E_V2 = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mdu_op = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ehi = 32'd0;
    elo = 32'd0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi_out, 32'd0);
    chk("abort_lo", bus.lo_out, 32'd0);
    run_op(4'd1, 32'd2, 32'd3, 1'b0);
    chk("post_lo", bus.lo_out, 32'd6);
    chk("post_hi", bus.hi_out, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 10));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0)
        ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1)
        b = b >> $urandom_range(0, 31);
      if (op == 4'd5 || op == 4'd6)
        read_op(op);
      else
        run_op(op, a, b,
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
